ps2_kbd_scheduler: RTL and testbench

//  Buffers keyboard scan-code bytes from the core's SPI/IO-controller side and plays them out
//  as device-to-host PS/2 frames on ps2_clk/ps2_data. The clock is generated internally from a

---
 rtl/ps2_kbd_scheduler_pkg.sv | 24 ++
 rtl/ps2_kbd_scheduler_byte_fifo.sv | 59 +++++
 rtl/ps2_kbd_scheduler.sv | 157 +++++++++++++++
 tb/tb_ps2_kbd_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_scheduler_pkg.sv
// Shared PS/2 frame definitions: frame length, scheduler state encodings, parity and frame builders.
// Frame vectors are time-ordered, so bit 0 is driven first.
package ps2_kbd_scheduler_pkg;

  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_BIT_HI = 3'd2,
    ST_BIT_LO = 3'd3,
    ST_GAP    = 3'd4
  } ps2_state_e;

  // Odd parity: ones in data plus parity bit is odd.
  function automatic logic ps2_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ps2_parity(b), b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_kbd_scheduler_byte_fifo.sv
// ps2_byte_fifo: 2^AW x 8 synchronous FWFT FIFO; level updates one cycle after push/pop.
// A push while full is accepted only if a pop happens in the same cycle; otherwise it is dropped.
module ps2_byte_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int            DEPTH    = 1 << AW;
  localparam logic [AW:0]   LVL_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d  = level_q;
    if (do_push && !do_pop) level_d = level_q + LVL_ONE;
    if (do_pop && !do_push) level_d = level_q - LVL_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ps2_kbd_scheduler.sv
// Queues scan-code bytes and replays them as PS/2 device-to-host frames; start bit 2 cycles after push into idle.
// byte_ready = FIFO not full; pushes while full are dropped with an overflow pulse (and drop_cnt if PS2_DROP_CNT_EN).
module ps2_kbd_scheduler
  import ps2_kbd_scheduler_pkg::*;
#(
  parameter int FIFO_AW     = 4,
  parameter int HALF_PERIOD = 1000,
  parameter int GAP_HALVES  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               ps2_clk,
  output logic               ps2_data,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow
`ifdef PS2_DROP_CNT_EN
  ,
  output logic [7:0]         drop_cnt
`endif
);

  localparam int            GAP_CYC   = GAP_HALVES * HALF_PERIOD;
  localparam int            TW        = $clog2(GAP_CYC + 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] GAP_EARLY = TW'(GAP_CYC - 2);
  localparam logic [3:0]    LAST_BIT  = 4'(PS2_FRAME_BITS - 1);
  localparam logic [3:0]    BIT_ONE   = 4'd1;

  ps2_state_e                state_q, state_d;
  logic [TW-1:0]             tick_q, tick_d;
  logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
  logic [3:0]                bit_idx_q, bit_idx_d;
  logic                      ps2_clk_q, ps2_clk_d;
  logic                      ps2_data_q, ps2_data_d;
  logic                      busy_q, busy_d;
  logic                      overflow_q, overflow_d;

  logic       fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;

  ps2_byte_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (byte_valid),
    .pop   (fifo_pop),
    .din   (byte_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign byte_ready = !fifo_full;
  assign ps2_clk    = ps2_clk_q;
  assign ps2_data   = ps2_data_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      frame_q    <= '1;
      bit_idx_q  <= '0;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      frame_q    <= frame_d;
      bit_idx_q  <= bit_idx_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    frame_d   = frame_q;
    bit_idx_d = bit_idx_q;
    fifo_pop  = 1'b0;
    if (state_q inside {ST_BIT_HI, ST_BIT_LO, ST_GAP}) tick_d = tick_q + TICK_ONE;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        fifo_pop  = 1'b1;
        frame_d   = ps2_frame(fifo_dout);
        bit_idx_d = '0;
        state_d   = ST_BIT_HI;
      end
      ST_BIT_HI: begin
        if (tick_q == HALF_LAST) state_d = ST_BIT_LO;
      end
      ST_BIT_LO: begin
        if (tick_q == HALF_LAST) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_GAP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_ONE;
            frame_d   = {1'b1, frame_q[PS2_FRAME_BITS-1:1]};
            state_d   = ST_BIT_HI;
          end
        end
      end
      ST_GAP: begin
        // The LOAD cycle also keeps both lines high, so a waiting byte leaves one cycle early
        // to keep the inter-frame idle time at exactly GAP_HALVES half-periods.
        if (tick_q == GAP_LAST) begin
          state_d = fifo_empty ? ST_IDLE : ST_LOAD;
        end else if (tick_q == GAP_EARLY && !fifo_empty) begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) tick_d = '0;
  end

  always_comb begin
    ps2_clk_d  = 1'b1;
    ps2_data_d = 1'b1;
    busy_d     = (state_d != ST_IDLE);
    if (state_d == ST_BIT_HI || state_d == ST_BIT_LO) ps2_data_d = frame_d[0];
    if (state_d == ST_BIT_LO) ps2_clk_d = 1'b0;
    overflow_d = byte_valid && fifo_full && !fifo_pop;
  end

`ifdef PS2_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (overflow_d && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ps2_kbd_scheduler.sv
// Bench for ps2_kbd_scheduler: directed scenarios plus random bytes, frames decoded from the
// lines at ps2_clk falls and compared with frames built from the pushed bytes.
module tb_ps2_kbd_scheduler;

  localparam int AW = 4;
  localparam int HP = 4;
  localparam int GH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready, ps2_clk, ps2_data, busy, overflow;
  logic [AW:0]   fifo_level;
`ifdef PS2_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  always #5 clk = ~clk;

  ps2_kbd_scheduler #(.FIFO_AW(AW), .HALF_PERIOD(HP), .GAP_HALVES(GH)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .busy       (busy),
    .fifo_level (fifo_level),
    .overflow   (overflow)
`ifdef PS2_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [10:0] got_q[$];
  int          frames_done = 0;
  int          mon_n = 0;
  bit          sb_en = 1'b1;
  logic [10:0] mon_bits = '0;
  logic        mon_prev_clk = 1'b1;
  logic        mon_held = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Time-ordered frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic p;
    p = ($countones(b) % 2 == 0);
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Line monitor: decode bits at ps2_clk falls, check data stays put while ps2_clk is low.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      mon_n = 0;
      mon_prev_clk = 1'b1;
    end else begin
      if (mon_prev_clk && !ps2_clk) begin
        mon_bits[mon_n] = ps2_data;
        mon_held = ps2_data;
        mon_n++;
        if (mon_n == 11) begin
          mon_n = 0;
          frames_done++;
          got_q.push_back(mon_bits);
          if (sb_en) begin
            chk("frame_was_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("frame_bits", 32'(mon_bits), 32'(frame_of(exp_q.pop_front())));
          end
        end
      end else if (!mon_prev_clk && !ps2_clk) begin
        chk("data_stable_while_low", 32'(ps2_data), 32'(mon_held));
      end
      mon_prev_clk = ps2_clk;
    end
  end

  initial begin
    int cyc, lows, last_rise, falls, gap, fd, ov_seen;
    logic prev;
    logic [7:0] b;
    logic [10:0] f;
    bit counting, gap_done;

    // Reset values
    tick(2);
    chk("rst_ps2_clk", ps2_clk, 1);
    chk("rst_ps2_data", ps2_data, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ready", byte_ready, 1);
    reset = 1'b0;
    tick(1);

    // 1: single byte 8'h1C
    byte_in = 8'h1C; byte_valid = 1'b1; exp_q.push_back(8'h1C);
    tick(1);
    byte_valid = 1'b0;
    chk("t1_level_after_push", fifo_level, 1);
    chk("t1_idle_busy", busy, 0);
    tick(1);
    chk("t1_load_busy", busy, 1);
    chk("t1_load_data", ps2_data, 1);
    tick(1);
    chk("t1_start_bit", ps2_data, 0);
    chk("t1_start_clk", ps2_clk, 1);
    cyc = 0; lows = 0; last_rise = 0; prev = ps2_clk;
    while (busy && cyc < 300) begin
      tick(1); cyc++;
      if (!ps2_clk) lows++;
      if (ps2_clk && !prev) last_rise = cyc;
      prev = ps2_clk;
    end
    chk("t1_frame_len", last_rise, 88);
    chk("t1_busy_drop_after_stop", cyc - last_rise, 8);
    chk("t1_low_cycles", lows, 44);
    chk("t1_frames", got_q.size(), 1);
    if (got_q.size() > 0) chk("t1_bits", got_q.pop_front(), 11'b10000111000);

    // 2: 8'h00 and 8'hFF back-to-back
    byte_in = 8'h00; byte_valid = 1'b1; exp_q.push_back(8'h00);
    tick(1);
    byte_in = 8'hFF; exp_q.push_back(8'hFF);
    tick(1);
    byte_valid = 1'b0;
    cyc = 0; falls = 0; gap = 0; counting = 0; gap_done = 0; prev = ps2_clk;
    while (busy && cyc < 400) begin
      tick(1); cyc++;
      if (prev && !ps2_clk) falls++;
      if (falls == 11 && !prev && ps2_clk && !gap_done) counting = 1;
      if (counting) begin
        if (ps2_data && ps2_clk) gap++;
        else begin counting = 0; gap_done = 1; end
      end
      prev = ps2_clk;
    end
    chk("t2_gap_seen", gap_done, 1);
    chk("t2_gap_cycles", gap, 2 * HP);
    chk("t2_frames", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      f = got_q.pop_front(); chk("t2_parity_00", f[9], 1);
      f = got_q.pop_front(); chk("t2_parity_ff", f[9], 1);
    end

    // 3: 17 pushes in 17 cycles, then one dropped push
    ov_seen = 0;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom); byte_in = b; byte_valid = 1'b1; exp_q.push_back(b);
      tick(1);
      ov_seen += int'(overflow);
    end
    chk("t3_no_overflow", ov_seen, 0);
    chk("t3_level_full", fifo_level, 16);
    chk("t3_ready_low", byte_ready, 0);
    byte_in = 8'($urandom);
    tick(1);
    byte_valid = 1'b0;
    chk("t3_overflow_pulse", overflow, 1);
    chk("t3_level_kept", fifo_level, 16);
    tick(1);
    chk("t3_overflow_single", overflow, 0);
`ifdef PS2_DROP_CNT_EN
    chk("t3_drop_cnt", drop_cnt, 1);
`endif

    // 4: push lands in the LOAD cycle of a full FIFO
    fd = frames_done; cyc = 0;
    while (frames_done == fd && cyc < 200) begin tick(1); cyc++; end
    chk("t4_frame_completed", 32'(frames_done != fd), 1);
    cyc = 0;
    while (!ps2_clk && cyc < 20) begin tick(1); cyc++; end
    tick(2 * HP - 1);
    chk("t4_pre_level", fifo_level, 16);
    chk("t4_pre_data", ps2_data, 1);
    b = 8'($urandom); byte_in = b; byte_valid = 1'b1;
    tick(1);
    byte_valid = 1'b0; exp_q.push_back(b);
    chk("t4_level_stays", fifo_level, 16);
    chk("t4_no_overflow", overflow, 0);
    chk("t4_start_bit", ps2_data, 0);

    // 5: reset in the low half of bit 5
    cyc = 0;
    while (mon_n != 6 && cyc < 300) begin tick(1); cyc++; end
    chk("t5_reached_bit5", mon_n, 6);
    chk("t5_clk_low_before", ps2_clk, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_clk", ps2_clk, 1);
    chk("t5_async_data", ps2_data, 1);
    chk("t5_async_level", fifo_level, 0);
    chk("t5_async_busy", busy, 0);
    exp_q.delete();
    got_q.delete();
    tick(2);
    reset = 1'b0;
    falls = 0; prev = ps2_clk;
    for (int i = 0; i < 150; i++) begin
      tick(1);
      if (prev && !ps2_clk) falls++;
      prev = ps2_clk;
    end
    chk("t5_no_resume", falls, 0);
    chk("t5_idle_busy", busy, 0);

    // Random bytes at random spacing, never enough to fill the FIFO
    for (int i = 0; i < 6; i++) begin
      tick($urandom_range(0, 120));
      chk("rnd_ready", byte_ready, 1);
      b = 8'($urandom); byte_in = b; byte_valid = 1'b1; exp_q.push_back(b);
      tick(1);
      byte_valid = 1'b0;
    end
    cyc = 0;
    while ((exp_q.size() != 0 || busy) && cyc < 2000) begin tick(1); cyc++; end
    chk("rnd_all_frames_out", exp_q.size(), 0);
    chk("rnd_idle", busy, 0);

`ifdef PS2_DROP_CNT_EN
    // 6: sustained pushes into a full FIFO saturate the drop counter
    sb_en = 1'b0;
    byte_valid = 1'b1;
    for (int i = 0; i < 330; i++) begin
      byte_in = 8'($urandom);
      tick(1);
    end
    byte_valid = 1'b0;
    tick(1);
    chk("t6_drop_cnt_sat", drop_cnt, 8'hFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
